// File: rtl/arb_req_ctrl.sv
// arb_req_ctrl: upstream requester for the 3-device priority grant arbiter.
// Each device owns an independent FSM (IDLE -> REQ -> XFER -> REL -> IDLE) that accepts one
// transfer job, raises its request, streams len+1 beats on the shared beat bus while granted,
// then drops its request and waits for the grant to clear.
//
// Ports:
//   clk, resetn      clock (posedge) and synchronous active-low reset
//   cmd_valid/ready  per-device job handshake (ready = device FSM idle)
//   cmd_len          per-device job length, device i at [i*LEN_W-1 -: LEN_W], N -> N+1 beats
//   r / g            registered request to / grant from the arbiter, bit i-1 = device i
//   beat_*           shared beat bus (combinational from state and g)
//   done, timeout    1-cycle per-device completion / no-grant abort pulses
//   grant_err        sticky grant protocol error flag
module arb_req_ctrl #(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [2:0]         cmd_valid,
  output logic [2:0]         cmd_ready,
  input  logic [3*LEN_W-1:0] cmd_len,
  output logic [2:0]         r,
  input  logic [2:0]         g,
  output logic               beat_valid,
  output logic [1:0]         beat_dev,
  output logic [LEN_W-1:0]   beat_idx,
  output logic               beat_last,
  output logic [2:0]         done,
  output logic [2:0]         timeout,
  output logic               grant_err
);

  // Wait counter only has to reach TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] ToLast = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StRel} state_t;

  state_t           state_q [3];
  logic [LEN_W-1:0] len_q   [3];
  logic [LEN_W-1:0] idx_q   [3];
  logic [CW-1:0]    wait_q  [3];

  logic g_onehot;
  logic g_multi;
  logic err_now;

  assign g_multi  = (g & (g - 3'd1)) != 3'd0;
  assign g_onehot = (g != 3'd0) && !g_multi;

  // A grant is only legal for a device that is requesting or still releasing.
  always_comb begin
    err_now = g_multi;
    for (int i = 0; i < 3; i++) begin
      if (g[i] && (state_q[i] == StIdle)) err_now = 1'b1;
    end
  end

  always_comb begin
    cmd_ready  = '0;
    beat_valid = 1'b0;
    beat_dev   = '0;
    beat_idx   = '0;
    beat_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_ready[i] = (state_q[i] == StIdle);
      // g one-hot guarantees at most one device matches.
      if ((state_q[i] == StXfer) && g_onehot && g[i]) begin
        beat_valid = 1'b1;
        beat_dev   = 2'(i + 1);
        beat_idx   = idx_q[i];
        beat_last  = (idx_q[i] == len_q[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r         <= '0;
      done      <= '0;
      timeout   <= '0;
      grant_err <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= StIdle;
        len_q[i]   <= '0;
        idx_q[i]   <= '0;
        wait_q[i]  <= '0;
      end
    end else begin
      done    <= '0;
      timeout <= '0;
      if (err_now) grant_err <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        unique case (state_q[i])
          StIdle: begin
            if (cmd_valid[i]) begin
              len_q[i]   <= cmd_len[i*LEN_W +: LEN_W];
              idx_q[i]   <= '0;
              wait_q[i]  <= '0;
              r[i]       <= 1'b1;
              state_q[i] <= StReq;
            end
          end
          StReq: begin
            // Grant wins over a timeout landing in the same cycle.
            if (g_onehot && g[i]) begin
              idx_q[i]   <= '0;
              state_q[i] <= StXfer;
            end else if ((TIMEOUT != 0) && (wait_q[i] == ToLast)) begin
              timeout[i] <= 1'b1;
              r[i]       <= 1'b0;
              state_q[i] <= StIdle;
            end else begin
              wait_q[i] <= wait_q[i] + 1'b1;
            end
          end
          StXfer: begin
            // Without a clean grant the job stalls with r held and idx kept.
            if (g_onehot && g[i]) begin
              if (idx_q[i] == len_q[i]) begin
                done[i]    <= 1'b1;
                r[i]       <= 1'b0;
                state_q[i] <= StRel;
              end else begin
                idx_q[i] <= idx_q[i] + 1'b1;
              end
            end
          end
          StRel: begin
            // Arbiter drops the grant a cycle or more after r falls.
            if (!g[i]) state_q[i] <= StIdle;
          end
          default: state_q[i] <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arb_req_ctrl.sv
module tb_arb_req_ctrl;

  localparam int LW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic [2:0]    cmd_valid;
  logic [2:0]    cmd_ready;
  logic [3*LW-1:0] cmd_len;
  logic [2:0]    r;
  logic [2:0]    g;
  logic          beat_valid;
  logic [1:0]    beat_dev;
  logic [LW-1:0] beat_idx;
  logic          beat_last;
  logic [2:0]    done;
  logic [2:0]    timeout;
  logic          grant_err;

  arb_req_ctrl #(.LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .r         (r),
    .g         (g),
    .beat_valid(beat_valid),
    .beat_dev  (beat_dev),
    .beat_idx  (beat_idx),
    .beat_last (beat_last),
    .done      (done),
    .timeout   (timeout),
    .grant_err (grant_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Job-level reference: per device a job is "busy" from accept until the grant is released;
  // within it the job is waiting for a grant, streaming beats, or releasing.
  bit       m_busy    [3];
  bit       m_started [3];
  bit       m_rel     [3];
  int       m_len     [3];
  int       m_idx     [3];
  int       m_age     [3];
  bit [2:0] m_done;
  bit [2:0] m_to;
  bit       m_err;

  // Environment arbiter (priority 1 > 2 > 3, holds grant while holder requests).
  bit auto_arb  = 1'b0;
  bit stall_en  = 1'b0;
  int hold      = 0;
  logic [2:0] g_next;

  int beats     [3];
  int done_cnt  [3];
  int to_cnt    [3];
  int done_at   [3];
  int cycle_no  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_busy[d] = 0; m_started[d] = 0; m_rel[d] = 0;
      m_len[d] = 0; m_idx[d] = 0; m_age[d] = 0;
    end
    m_done = '0; m_to = '0; m_err = 0; hold = 0;
  endtask

  task automatic model_step();
    if (!resetn) begin
      model_reset();
      return;
    end
    if ($countones(g) > 1) m_err = 1;
    for (int d = 0; d < 3; d++) if (g[d] && !m_busy[d]) m_err = 1;
    m_done = '0;
    m_to   = '0;
    for (int d = 0; d < 3; d++) begin
      bit oh;
      oh = (g == 3'(1 << d));
      if (!m_busy[d]) begin
        if (cmd_valid[d]) begin
          m_busy[d] = 1; m_started[d] = 0; m_rel[d] = 0; m_age[d] = 0; m_idx[d] = 0;
          m_len[d]  = int'(cmd_len[d*LW +: LW]);
        end
      end else if (!m_started[d]) begin
        if (oh) begin
          m_started[d] = 1;
          m_idx[d]     = 0;
        end else begin
          m_age[d]++;
          if (m_age[d] == TO) begin
            m_to[d]   = 1;
            m_busy[d] = 0;
          end
        end
      end else if (!m_rel[d]) begin
        if (oh) begin
          if (m_idx[d] == m_len[d]) begin
            m_rel[d]  = 1;
            m_done[d] = 1;
          end else begin
            m_idx[d]++;
          end
        end
      end else if (!g[d]) begin
        m_busy[d] = 0;
      end
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      logic [2:0] e_ready, e_r;
      int e_dev, e_idx;
      bit e_last;
      @(negedge clk);
      e_dev = 0;
      for (int d = 0; d < 3; d++) begin
        e_ready[d] = !m_busy[d];
        e_r[d]     = m_busy[d] && !m_rel[d];
        if (m_busy[d] && m_started[d] && !m_rel[d] && (g == 3'(1 << d))) e_dev = d + 1;
      end
      e_idx  = (e_dev != 0) ? m_idx[e_dev-1] : 0;
      e_last = (e_dev != 0) && (m_idx[e_dev-1] == m_len[e_dev-1]);
      chk("cmd_ready",  32'(cmd_ready),  32'(e_ready));
      chk("r",          32'(r),          32'(e_r));
      chk("beat_valid", 32'(beat_valid), 32'(e_dev != 0));
      chk("beat_dev",   32'(beat_dev),   32'(e_dev));
      chk("beat_idx",   32'(beat_idx),   32'(e_idx));
      chk("beat_last",  32'(beat_last),  32'(e_last));
      chk("done",       32'(done),       32'(m_done));
      chk("timeout",    32'(timeout),    32'(m_to));
      chk("grant_err",  32'(grant_err),  32'(m_err));
      if (beat_valid && beat_dev != 2'd0) beats[beat_dev-1]++;
      for (int d = 0; d < 3; d++) begin
        if (done[d]) begin done_cnt[d]++; done_at[d] = cycle_no; end
        if (timeout[d]) to_cnt[d]++;
      end
      // Arbiter decision from the requests visible this cycle.
      if (!(hold != 0 && e_r[hold-1])) begin
        hold = 0;
        for (int d = 2; d >= 0; d--) if (e_r[d]) hold = d + 1;
      end
      g_next = (hold != 0) ? 3'(1 << (hold - 1)) : 3'b000;
      if (stall_en && $urandom_range(0, 3) == 0) g_next = 3'b000;
      if (!resetn) begin hold = 0; g_next = 3'b000; end
      @(posedge clk);
      model_step();
      #1;
      if (auto_arb) g = g_next;
      cycle_no++;
    end
  endtask

  task automatic clr_tally();
    for (int d = 0; d < 3; d++) begin
      beats[d] = 0; done_cnt[d] = 0; to_cnt[d] = 0; done_at[d] = -1;
    end
  endtask

  task automatic set_len(input int d, input int len);
    cmd_len[d*LW +: LW] = LW'(len);
  endtask

  initial begin
    resetn = 1'b0; cmd_valid = '0; cmd_len = '0; g = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    clr_tally();
    cyc(1);
    resetn = 1'b1;
    cyc(1);

    // T1: dev1 len=3, grant two cycles after request.
    clr_tally();
    set_len(0, 3); cmd_valid = 3'b001; cyc(1);
    cmd_valid = '0; cyc(2);
    g = 3'b001; cyc(5);
    cyc(1);           // REL with grant still high: no beats
    g = 3'b000; cyc(2);
    chk("t1_beats", 32'(beats[0]), 32'd4);
    chk("t1_done",  32'(done_cnt[0]), 32'd1);

    // T2: dev1 len=1 and dev3 len=0 together, arbiter model.
    clr_tally();
    auto_arb = 1'b1;
    set_len(0, 1); set_len(2, 0); cmd_valid = 3'b101; cyc(1);
    cmd_valid = '0; cyc(14);
    chk("t2_beats1", 32'(beats[0]), 32'd2);
    chk("t2_beats3", 32'(beats[2]), 32'd1);
    chk("t2_order",  32'(done_at[0] < done_at[2] && done_at[0] >= 0), 32'd1);
    auto_arb = 1'b0; g = '0; cyc(1);

    // T3: dev2 job, grant never given.
    clr_tally();
    set_len(1, 5); cmd_valid = 3'b010; cyc(1);
    cmd_valid = '0; cyc(10);
    chk("t3_to",    32'(to_cnt[1]), 32'd1);
    chk("t3_beats", 32'(beats[1]), 32'd0);

    // T4: dev1 len=5, grant gap of 3 cycles mid-job.
    clr_tally();
    set_len(0, 5); cmd_valid = 3'b001; cyc(1);
    cmd_valid = '0; g = 3'b001; cyc(3);
    g = 3'b000; cyc(3);
    g = 3'b001; cyc(5);
    g = 3'b000; cyc(2);
    chk("t4_beats", 32'(beats[0]), 32'd6);
    chk("t4_done",  32'(done_cnt[0]), 32'd1);

    // T6: reset during dev2 len=7 transfer at idx 3, then a fresh job.
    clr_tally();
    set_len(1, 7); cmd_valid = 3'b010; cyc(1);
    cmd_valid = '0; g = 3'b010; cyc(4);
    resetn = 1'b0; g = 3'b000; cyc(1);
    resetn = 1'b1; cyc(2);
    chk("t6_done", 32'(done_cnt[1]), 32'd0);
    set_len(1, 0); cmd_valid = 3'b010; cyc(1);
    cmd_valid = '0; g = 3'b010; cyc(3);
    g = 3'b000; cyc(2);
    chk("t6_new_done", 32'(done_cnt[1]), 32'd1);

    // T5: multi-hot grant in the middle of a dev1 transfer.
    clr_tally();
    set_len(0, 2); cmd_valid = 3'b001; cyc(1);
    cmd_valid = '0; g = 3'b001; cyc(2);
    g = 3'b011; cyc(1);
    g = 3'b001; cyc(3);
    g = 3'b000; cyc(3);
    chk("t5_beats", 32'(beats[0]), 32'd3);

    // Randomized traffic against the arbiter model, with random grant stalls.
    resetn = 1'b0; cyc(2);
    resetn = 1'b1;
    auto_arb = 1'b1; stall_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      cmd_len   = (3*LW)'($urandom);
      cyc(1);
    end
    cmd_valid = '0; stall_en = 1'b0;
    cyc(80);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
